gray_cntr_rx: RTL and testbench
===============================

Name: gray_cntr_rx

Overview:
- Receive-side counterpart of the 4-bit Gray counter: samples a Gray-coded count bus on each enabled cycle, converts it back to binary and checks that the sequence advances by exactly one step.
- Declares lock after a run of good steps, flags step errors and drops lock after repeated errors.
- Sits at the far end of a Gray count bus, typically after a clock-domain or board crossing, as the consumer and monitor of the counter output.

Parameters:
- WIDTH, 4, width of the Gray input and binary output.
- LOCK_CNT, 3, consecutive good steps required to enter LOCK (1..15).
- ERR_LIMIT, 2, consecutive bad steps in LOCK that force return to UNLOCK (1..15).
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cen  in  1  sample enable; gray_in is sampled on a rising edge only when cen=1.
- gray_in  in  WIDTH  Gray-coded count from the transmitter.
- bin_out  out  WIDTH  registered binary value of the last sample.
- bin_valid  out  1  one-cycle pulse: bin_out has been updated.
- step_err  out  1  step-error flag (pulse, or sticky under the option).
- wrap  out  1  one-cycle pulse on a good step from 2^WIDTH-1 to 0.
- locked  out  1  high in LOCK.
- err_cnt  out  ERRW  total step errors since reset, saturating at all ones.

Behaviour:
- Reset: takes effect on any edge with rst=1 and overrides cen.
  - Clears bin_out, bin_valid, step_err, wrap, locked, err_cnt, the internal previous value, the first-sample flag and the run counters.
  - State returns to UNLOCK.
  - Reset mid-run discards all history; the next sample is treated as a first sample.
- Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i=WIDTH-2..0.
  - Purely combinational ahead of the registers.
  - Total latency is one cycle: a sample taken at edge N appears on bin_out with bin_valid=1 after edge N.
- cen=0: bin_out, the previous value and the run counters hold. bin_valid, wrap and (non-sticky) step_err are 0.
- Sample with cen=1:
  - First sample after reset: loads bin_out and the previous value. No step check, so it is neither good nor bad.
  - Later samples: good step iff new_bin == (prev_bin+1) mod 2^WIDTH. Anything else is a bad step, including an unchanged value and a backward jump.
  - Every sample, good or bad, loads bin_out and prev_bin.
- Good step: wrap=1 if prev_bin = 2^WIDTH-1 and new_bin = 0.
- Bad step:
  - step_err=1 for that cycle.
  - err_cnt increments unless it is already all ones.
  - wrap=0.
- State machine (two states):
  - UNLOCK: good_run counts consecutive good steps; a bad step clears it. When the good step that makes good_run reach LOCK_CNT is taken, move to LOCK; locked=1 from the following cycle. Bad steps in UNLOCK still flag step_err and count.
  - LOCK: bad_run counts consecutive bad steps; a good step clears it. When the bad step that makes bad_run reach ERR_LIMIT is taken, move to UNLOCK, clear good_run and set locked=0 from the following cycle.
- Simultaneous events: rst has priority over cen. A step completing a lock or unlock transition both updates outputs and changes state on the same edge.

Optional Feature:
- Macro GRAY_CNTR_RX_STICKY_EN.
- Defined: step_err sets on the first bad step and stays 1 until rst. err_cnt, locked and the state machine behave exactly as without the macro.
- Undefined: step_err is a one-cycle pulse per bad step.

Test Plan (WIDTH=4, LOCK_CNT=3, ERR_LIMIT=2):
- Reset then cen=1 every cycle, gray 0000,0001,0011,0010 -> bin_out 0,1,2,3 each one cycle after its sample; locked=1 the cycle after the 0010 sample; step_err=0; err_cnt=0.
- Full ascending run 0..15 then 1000 (15) -> 0000 (0) -> wrap=1 for exactly one cycle alongside bin_out=0; no step_err.
- Locked at bin 5 (0111), send 0101 (6), then 0111 (5), then 0101 (6) -> step_err pulses once on the 0111 sample; err_cnt=1; locked stays 1 (bad_run=1, then cleared by the good step).
- Locked, two consecutive bad samples 1111 (10) after bin 3, then 1110 (11) -> err_cnt=2; locked=0 the cycle after the second bad sample; relock requires 3 further good steps.
- cen toggled 1,0,0,1 with gray 0001 then 0011 -> bin_valid high only on the cen=1 samples; bin_out holds 1 during the gaps; the step 1->2 is good.
- rst asserted for one cycle in LOCK with cen=1 -> all outputs 0 the next cycle; next sample 0110 (4) is accepted as a first sample with no step_err; optionally with GRAY_CNTR_RX_STICKY_EN, a prior sticky step_err is cleared by this rst.

Source files
------------

// File: rtl/gray_cntr_rx_if.sv
// rtl/gray_cntr_rx_if.sv - Gray count bus and monitor status bundle for gray_cntr_rx
interface gray_cntr_rx_if #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
);
  logic             cen;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_err;
  logic             wrap;
  logic             locked;
  logic [ERRW-1:0]  err_cnt;

  modport master (
    output cen, gray_in,
    input  bin_out, bin_valid, step_err, wrap, locked, err_cnt
  );

  modport slave (
    input  cen, gray_in,
    output bin_out, bin_valid, step_err, wrap, locked, err_cnt
  );
endinterface

// File: rtl/gray_cntr_rx.sv
// rtl/gray_cntr_rx.sv - Gray count receiver: decode, step check, lock tracking (option: GRAY_CNTR_RX_STICKY_EN)
module gray_cntr_rx #(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 3,
  parameter int ERR_LIMIT = 2,
  parameter int ERRW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  gray_cntr_rx_if.slave bus
);
  typedef enum logic {UNLOCK, LOCK} state_t;

  localparam logic [3:0] LOCK_N = LOCK_CNT[3:0];
  localparam logic [3:0] ERR_N  = ERR_LIMIT[3:0];

  state_t           state;
  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] bin_q;
  logic             have_prev;
  logic [3:0]       good_run;
  logic [3:0]       bad_run;
  logic             valid_q;
  logic             step_err_q;
  logic             wrap_q;
  logic             locked_q;
  logic [ERRW-1:0]  err_cnt_q;
  logic             good_step;

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    new_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_bin[i] = ^(bus.gray_in >> i);
    end
  end

  assign good_step = (new_bin == prev_bin + WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UNLOCK;
      prev_bin   <= '0;
      bin_q      <= '0;
      have_prev  <= 1'b0;
      good_run   <= '0;
      bad_run    <= '0;
      valid_q    <= 1'b0;
      step_err_q <= 1'b0;
      wrap_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      valid_q <= bus.cen;
      wrap_q  <= 1'b0;
`ifndef GRAY_CNTR_RX_STICKY_EN
      step_err_q <= 1'b0;
`endif
      if (bus.cen) begin
        bin_q     <= new_bin;
        prev_bin  <= new_bin;
        have_prev <= 1'b1;
        if (have_prev) begin
          if (good_step) begin
            wrap_q <= (prev_bin == '1);
            if (state == LOCK) begin
              bad_run <= '0;
            end else if (good_run + 4'd1 == LOCK_N) begin
              state    <= LOCK;
              locked_q <= 1'b1;
              good_run <= '0;
              bad_run  <= '0;
            end else begin
              good_run <= good_run + 4'd1;
            end
          end else begin
            step_err_q <= 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_q <= err_cnt_q + ERRW'(1);
            end
            if (state == UNLOCK) begin
              good_run <= '0;
            end else if (bad_run + 4'd1 == ERR_N) begin
              state    <= UNLOCK;
              locked_q <= 1'b0;
              good_run <= '0;
              bad_run  <= '0;
            end else begin
              bad_run <= bad_run + 4'd1;
            end
          end
        end
      end
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = valid_q;
  assign bus.step_err  = step_err_q;
  assign bus.wrap      = wrap_q;
  assign bus.locked    = locked_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_gray_cntr_rx.sv
// tb/tb_gray_cntr_rx.sv - randomized and directed bench for gray_cntr_rx against a behavioural model
module tb_gray_cntr_rx;
  localparam int WIDTH     = 4;
  localparam int LOCK_CNT  = 3;
  localparam int ERR_LIMIT = 2;
  localparam int ERRW      = 8;
  localparam int MODV      = 1 << WIDTH;
  localparam int ERR_MAX   = (1 << ERRW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  gray_cntr_rx_if #(.WIDTH(WIDTH), .ERRW(ERRW)) bus ();

  gray_cntr_rx #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .ERRW(ERRW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural expectation of every output after the most recent edge.
  bit m_first, m_locked, m_valid, m_step, m_wrap;
  int m_prev, m_bin, m_good, m_bad, m_err;

  function automatic int to_gray(int b);
    return (b ^ (b >> 1)) % MODV;
  endfunction

  function automatic int from_gray(int g);
    int r = 0;
    for (int b = 0; b < MODV; b++) begin
      if (to_gray(b) == g) r = b;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input int g);
    int  b;
    bit  good;
    if (r) begin
      m_first = 1; m_locked = 0; m_valid = 0; m_step = 0; m_wrap = 0;
      m_prev = 0; m_bin = 0; m_good = 0; m_bad = 0; m_err = 0;
    end else begin
      m_valid = c;
      m_wrap  = 0;
`ifndef GRAY_CNTR_RX_STICKY_EN
      m_step = 0;
`endif
      if (c) begin
        b = from_gray(g);
        if (!m_first) begin
          good = (b == (m_prev + 1) % MODV);
          if (good) begin
            m_wrap = (m_prev == MODV - 1) && (b == 0);
            if (m_locked) m_bad = 0;
            else begin
              m_good++;
              if (m_good == LOCK_CNT) begin m_locked = 1; m_good = 0; m_bad = 0; end
            end
          end else begin
            m_step = 1;
            if (m_err < ERR_MAX) m_err++;
            if (!m_locked) m_good = 0;
            else begin
              m_bad++;
              if (m_bad == ERR_LIMIT) begin m_locked = 0; m_good = 0; m_bad = 0; end
            end
          end
        end
        m_bin = b; m_prev = b; m_first = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("bin_out",   bus.bin_out,   m_bin);
    check("bin_valid", bus.bin_valid, m_valid);
    check("step_err",  bus.step_err,  m_step);
    check("wrap",      bus.wrap,      m_wrap);
    check("locked",    bus.locked,    m_locked);
    check("err_cnt",   bus.err_cnt,   m_err);
  endtask

  task automatic cycle(input bit r, input bit c, input int g);
    rst = r; bus.cen = c; bus.gray_in = WIDTH'(g);
    @(posedge clk);
    #1;
    model_step(r, c, g);
    compare_all();
  endtask

  task automatic send_bin(input int b);
    cycle(0, 1, to_gray(b));
  endtask

  task automatic send_run(input int from, input int to);
    for (int b = from; b <= to; b++) send_bin(b);
  endtask

  initial begin
    int tx;
    bit r, c;
    rst = 1'b1; bus.cen = 1'b0; bus.gray_in = '0;
    cycle(1, 0, 0);
    check("lit_reset_locked", bus.locked, 0);
    check("lit_reset_err", bus.err_cnt, 0);

    // Lock after 3 good steps.
    cycle(1, 0, 0);
    cycle(0, 1, 4'b0000); cycle(0, 1, 4'b0001); cycle(0, 1, 4'b0011);
    check("lit_s1_unlocked", bus.locked, 0);
    cycle(0, 1, 4'b0010);
    check("lit_s1_bin", bus.bin_out, 3);
    check("lit_s1_locked", bus.locked, 1);

    // Wrap from 15 to 0.
    cycle(1, 0, 0);
    send_run(0, 15);
    cycle(0, 1, 4'b0000);
    check("lit_s2_wrap", bus.wrap, 1);
    check("lit_s2_bin", bus.bin_out, 0);
    cycle(0, 0, 0);
    check("lit_s2_wrap_drop", bus.wrap, 0);

    // Single bad step while locked.
    cycle(1, 0, 0);
    send_run(0, 5);
    cycle(0, 1, 4'b0101); cycle(0, 1, 4'b0111);
    check("lit_s3_step_err", bus.step_err, 1);
    cycle(0, 1, 4'b0101);
    check("lit_s3_err_cnt", bus.err_cnt, 1);
    check("lit_s3_locked", bus.locked, 1);

    // Two bad steps drop lock; relock after 3 good steps.
    cycle(1, 0, 0);
    send_run(0, 3);
    cycle(0, 1, 4'b1111);
    cycle(0, 1, 4'b1111);
    check("lit_s4_unlocked", bus.locked, 0);
    cycle(0, 1, 4'b1110);
    check("lit_s4_err_cnt", bus.err_cnt, 2);
    send_run(12, 12);
    check("lit_s4_not_yet", bus.locked, 0);
    send_run(13, 13);
    check("lit_s4_relocked", bus.locked, 1);

    // Enable gaps hold the value.
    cycle(1, 0, 0);
    cycle(0, 1, 4'b0001);
    cycle(0, 0, 4'b1010);
    check("lit_s5_hold", bus.bin_out, 1);
    check("lit_s5_novalid", bus.bin_valid, 0);
    cycle(0, 0, 4'b1010);
    cycle(0, 1, 4'b0011);
    check("lit_s5_bin", bus.bin_out, 2);
    check("lit_s5_err", bus.err_cnt, 0);

    // Reset in LOCK with cen=1, then a fresh first sample.
    cycle(1, 0, 0);
    send_run(0, 3);
    cycle(0, 1, 4'b0000);
    cycle(1, 1, 4'b0011);
    check("lit_s6_rst_locked", bus.locked, 0);
    check("lit_s6_rst_err", bus.step_err, 0);
    cycle(0, 1, 4'b0110);
    check("lit_s6_first_bin", bus.bin_out, 4);
    check("lit_s6_first_err", bus.step_err, 0);

    // Random traffic: mostly good steps, some glitches, gaps and resets.
    tx = 4;
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 3) != 0);
      if (c) begin
        if ($urandom_range(0, 99) < 85) tx = (tx + 1) % MODV;
        else tx = $urandom_range(0, MODV - 1);
      end
      cycle(r, c, to_gray(tx));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
